// File: rtl/clk_div_meas.sv
// ============================================================================
// Module      : clk_div_meas
// Description : Measures period and high time of a slow or asynchronous clock
//               in master-clock cycles and recovers its divide ratio.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_meas #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int LOCK_CNT    = 4
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_meas_clk,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high,
    output logic [7:0]       o_divn,
    output logic             o_valid,
    output logic             o_locked,
    output logic             o_timeout
);

    localparam int               c_match_w  = $clog2(LOCK_CNT + 1);
    localparam int               c_ext_w    = (CNT_W > 8) ? CNT_W : 9;
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [c_match_w-1:0] c_lock_cnt = c_match_w'(LOCK_CNT);
    localparam logic [c_ext_w-1:0]   c_divn_max = c_ext_w'(255);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_EDGE = 2'd1,
        ST_MEASURE   = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync_q;
    logic [SYNC_STAGES-1:0] w_sync_d;
    logic                   r_s_dly_q;
    state_t                 r_state_q;
    state_t                 w_state_d;
    logic [CNT_W-1:0]       r_cnt_q;
    logic [CNT_W-1:0]       w_cnt_d;
    logic [CNT_W-1:0]       r_hcnt_q;
    logic [CNT_W-1:0]       w_hcnt_d;
    logic [CNT_W-1:0]       r_period_q;
    logic [CNT_W-1:0]       w_period_d;
    logic [CNT_W-1:0]       r_high_q;
    logic [CNT_W-1:0]       w_high_d;
    logic [7:0]             r_divn_q;
    logic [7:0]             w_divn_d;
    logic                   r_valid_q;
    logic                   w_valid_d;
    logic                   r_locked_q;
    logic                   w_locked_d;
    logic                   r_timeout_q;
    logic                   w_timeout_d;
    logic [c_match_w-1:0]   r_match_q;
    logic [c_match_w-1:0]   w_match_d;
    logic                   r_have_cap_q;
    logic                   w_have_cap_d;

    logic                   w_s;
    logic                   w_rise;
    logic [CNT_W-1:0]       w_cnt_inc;
    logic [CNT_W-1:0]       w_hcnt_inc;
    logic [c_ext_w-1:0]     w_cnt_ext;
    logic [7:0]             w_divn_cap;
    logic                   w_period_same;
    logic [c_match_w-1:0]   w_match_cap;

    assign w_sync_d      = {r_sync_q[SYNC_STAGES-2:0], i_meas_clk};
    assign w_s           = r_sync_q[SYNC_STAGES-1];
    assign w_rise        = w_s & ~r_s_dly_q;
    assign w_cnt_inc     = (r_cnt_q == c_cnt_max) ? r_cnt_q : r_cnt_q + c_cnt_one;
    assign w_hcnt_inc    = (r_hcnt_q == c_cnt_max) ? r_hcnt_q : r_hcnt_q + c_cnt_one;
    assign w_cnt_ext     = c_ext_w'(r_cnt_q);
    assign w_divn_cap    = (w_cnt_ext > c_divn_max) ? 8'hFF : w_cnt_ext[7:0];

    // The last captured period doubles as the comparison reference; the
    // have_cap flag says whether it belongs to the current measurement run.
    assign w_period_same = r_have_cap_q && (r_cnt_q == r_period_q);
    assign w_match_cap   = !w_period_same            ? '0 :
                           (r_match_q == c_lock_cnt) ? r_match_q :
                                                       r_match_q + c_match_w'(1);

    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_d      = r_cnt_q;
        w_hcnt_d     = r_hcnt_q;
        w_period_d   = r_period_q;
        w_high_d     = r_high_q;
        w_divn_d     = r_divn_q;
        w_valid_d    = 1'b0;
        w_locked_d   = r_locked_q;
        w_timeout_d  = r_timeout_q;
        w_match_d    = r_match_q;
        w_have_cap_d = r_have_cap_q;

        if (!i_en) begin
            w_state_d    = ST_IDLE;
            w_cnt_d      = '0;
            w_hcnt_d     = '0;
            w_locked_d   = 1'b0;
            w_timeout_d  = 1'b0;
            w_match_d    = '0;
            w_have_cap_d = 1'b0;
        end else begin
            case (r_state_q)
                ST_IDLE: begin
                    w_state_d = ST_WAIT_EDGE;
                    w_cnt_d   = '0;
                    w_hcnt_d  = '0;
                end
                ST_WAIT_EDGE: begin
                    if (w_rise) begin
                        w_state_d = ST_MEASURE;
                        w_cnt_d   = c_cnt_one;
                        w_hcnt_d  = c_cnt_one;
                    end else if (r_cnt_q == c_cnt_max) begin
                        w_timeout_d  = 1'b1;
                        w_locked_d   = 1'b0;
                        w_match_d    = '0;
                        w_have_cap_d = 1'b0;
                        w_cnt_d      = '0;
                    end else begin
                        w_cnt_d = w_cnt_inc;
                    end
                end
                ST_MEASURE: begin
                    // A rise wins over a simultaneous timeout.
                    if (w_rise) begin
                        w_period_d   = r_cnt_q;
                        w_high_d     = r_hcnt_q;
                        w_divn_d     = w_divn_cap;
                        w_valid_d    = 1'b1;
                        w_timeout_d  = 1'b0;
                        w_match_d    = w_match_cap;
                        w_locked_d   = (w_match_cap == c_lock_cnt);
                        w_have_cap_d = 1'b1;
                        w_cnt_d      = c_cnt_one;
                        w_hcnt_d     = c_cnt_one;
                    end else if (r_cnt_q == c_cnt_max) begin
                        w_state_d    = ST_WAIT_EDGE;
                        w_timeout_d  = 1'b1;
                        w_locked_d   = 1'b0;
                        w_match_d    = '0;
                        w_have_cap_d = 1'b0;
                        w_cnt_d      = '0;
                        w_hcnt_d     = '0;
                    end else begin
                        w_cnt_d = w_cnt_inc;
                        if (w_s) begin
                            w_hcnt_d = w_hcnt_inc;
                        end
                    end
                end
                default: begin
                    w_state_d = ST_IDLE;
                    w_cnt_d   = '0;
                    w_hcnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_sync_q     <= '0;
            r_s_dly_q    <= 1'b0;
            r_state_q    <= ST_IDLE;
            r_cnt_q      <= '0;
            r_hcnt_q     <= '0;
            r_period_q   <= '0;
            r_high_q     <= '0;
            r_divn_q     <= '0;
            r_valid_q    <= 1'b0;
            r_locked_q   <= 1'b0;
            r_timeout_q  <= 1'b0;
            r_match_q    <= '0;
            r_have_cap_q <= 1'b0;
        end else begin
            r_sync_q     <= w_sync_d;
            r_s_dly_q    <= w_s;
            r_state_q    <= w_state_d;
            r_cnt_q      <= w_cnt_d;
            r_hcnt_q     <= w_hcnt_d;
            r_period_q   <= w_period_d;
            r_high_q     <= w_high_d;
            r_divn_q     <= w_divn_d;
            r_valid_q    <= w_valid_d;
            r_locked_q   <= w_locked_d;
            r_timeout_q  <= w_timeout_d;
            r_match_q    <= w_match_d;
            r_have_cap_q <= w_have_cap_d;
        end
    end

    assign o_period  = r_period_q;
    assign o_high    = r_high_q;
    assign o_divn    = r_divn_q;
    assign o_valid   = r_valid_q;
    assign o_locked  = r_locked_q;
    assign o_timeout = r_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_meas.sv
// ============================================================================
// Module      : tb_clk_div_meas
// Description : Scoreboard bench for clk_div_meas (16-bit and 8-bit counters).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_clk_div_meas;

    typedef struct packed {
        logic [15:0] period;
        logic [15:0] high;
        logic [7:0]  divn;
        logic        locked;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  meas;
    logic [1:0]  en;

    logic [15:0] w_pa, w_ha;
    logic [7:0]  w_da;
    logic        w_va, w_la, w_ta;
    logic [7:0]  w_pb, w_hb;
    logic [7:0]  w_db;
    logic        w_vb, w_lb, w_tb;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t e_a, e_b;

    int   m_len[2], m_hi[2], m_last[2], m_match[2];
    bit   m_have_rise[2], m_have_cap[2];
    int   n_valid[2];
    int   last_valid_cyc[2];

    clk_div_meas #(.SYNC_STAGES(2), .CNT_W(16), .LOCK_CNT(4)) dut_a (
        .i_clk(clk), .i_resetn(rst_n), .i_meas_clk(meas[0]), .i_en(en[0]),
        .o_period(w_pa), .o_high(w_ha), .o_divn(w_da),
        .o_valid(w_va), .o_locked(w_la), .o_timeout(w_ta)
    );

    clk_div_meas #(.SYNC_STAGES(2), .CNT_W(8), .LOCK_CNT(4)) dut_b (
        .i_clk(clk), .i_resetn(rst_n), .i_meas_clk(meas[1]), .i_en(en[1]),
        .o_period(w_pb), .o_high(w_hb), .o_divn(w_db),
        .o_valid(w_vb), .o_locked(w_lb), .o_timeout(w_tb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Capture monitor: every o_valid pops one expected capture.
    always @(negedge clk) begin
        if (w_va === 1'b1) begin
            n_valid[0]++;
            last_valid_cyc[0] = cyc;
            n_tests++;
            if (qa.size() == 0) begin
                n_fail++;
                $display("FAIL capture_a: unexpected o_valid, period=%0d high=%0d", w_pa, w_ha);
            end else begin
                e_a = qa.pop_front();
                if ({w_pa, w_ha, w_da, w_la, w_ta} !== {e_a.period, e_a.high, e_a.divn, e_a.locked, 1'b0}) begin
                    n_fail++;
                    $display("FAIL capture_a: got period=%0d high=%0d divn=%0d locked=%0b timeout=%0b, expected %0d %0d %0d %0b 0",
                             w_pa, w_ha, w_da, w_la, w_ta, e_a.period, e_a.high, e_a.divn, e_a.locked);
                end
            end
        end
        if (w_vb === 1'b1) begin
            n_valid[1]++;
            last_valid_cyc[1] = cyc;
            n_tests++;
            if (qb.size() == 0) begin
                n_fail++;
                $display("FAIL capture_b: unexpected o_valid, period=%0d high=%0d", w_pb, w_hb);
            end else begin
                e_b = qb.pop_front();
                if ({16'(w_pb), 16'(w_hb), w_db, w_lb, w_tb} !== {e_b.period, e_b.high, e_b.divn, e_b.locked, 1'b0}) begin
                    n_fail++;
                    $display("FAIL capture_b: got period=%0d high=%0d divn=%0d locked=%0b timeout=%0b, expected %0d %0d %0d %0b 0",
                             w_pb, w_hb, w_db, w_lb, w_tb, e_b.period, e_b.high, e_b.divn, e_b.locked);
                end
            end
        end
    end

    function automatic void model_clear(input int s);
        m_have_rise[s] = 1'b0;
        m_have_cap[s]  = 1'b0;
        m_match[s]     = 0;
        m_len[s]       = 0;
        m_hi[s]        = 0;
    endfunction

    function automatic int qsize(input int s);
        return (s == 0) ? qa.size() : qb.size();
    endfunction

    // A rise closes the running period: push what the DUT must capture.
    task automatic model_rise(input int s);
        exp_t e;
        if (m_have_rise[s]) begin
            if (m_have_cap[s] && m_len[s] == m_last[s])
                m_match[s] = (m_match[s] >= 4) ? 4 : m_match[s] + 1;
            else
                m_match[s] = 0;
            m_have_cap[s] = 1'b1;
            m_last[s]     = m_len[s];
            e.period = 16'(m_len[s]);
            e.high   = 16'(m_hi[s]);
            e.divn   = (m_len[s] > 255) ? 8'hFF : 8'(m_len[s]);
            e.locked = (m_match[s] == 4);
            if (s == 0) qa.push_back(e);
            else        qb.push_back(e);
        end
        m_have_rise[s] = 1'b1;
        m_len[s]       = 0;
        m_hi[s]        = 0;
    endtask

    task automatic tick(input int s, input logic v);
        if (v && !meas[s]) model_rise(s);
        meas[s] = v;
        m_len[s]++;
        if (v) m_hi[s]++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wave(input int s, input int hi, input int lo, input int n);
        repeat (n) begin
            repeat (hi) tick(s, 1'b1);
            repeat (lo) tick(s, 1'b0);
        end
    endtask

    task automatic drain(input int s);
        int k = 0;
        while (qsize(s) != 0 && k < 60) begin
            tick(s, 1'b0);
            k++;
        end
        n_tests++;
        if (qsize(s) != 0) begin
            n_fail++;
            $display("FAIL drain_%0d: %0d captures outstanding, expected 0", s, qsize(s));
            if (s == 0) qa.delete();
            else        qb.delete();
        end
    endtask

    task automatic set_en(input int s, input logic v);
        en[s] = v;
        model_clear(s);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        en[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            meas[0] = ~meas[0];
            @(posedge clk);
            #1;
            n_tests++;
            if ({w_pa, w_ha, w_da, w_va, w_la, w_ta} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: got period=%0d high=%0d divn=%0d valid=%0b locked=%0b timeout=%0b, expected all 0",
                         w_pa, w_ha, w_da, w_va, w_la, w_ta);
            end
        end
        rst_n = 1'b1;
        model_clear(0);
        drive_wave(0, 2, 1, 1);
        repeat (5) tick(0, 1'b0);
        n_tests++;
        if (n_valid[0] !== 0) begin
            n_fail++;
            $display("FAIL reset_one_rise: got %0d captures, expected 0", n_valid[0]);
        end
        drive_wave(0, 2, 1, 4);
        drain(0);
        n_tests++;
        if (n_valid[0] !== 4) begin
            n_fail++;
            $display("FAIL reset_capture_count: got %0d, expected 4", n_valid[0]);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({w_pa, w_ha, w_da, w_la} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got period=%0d high=%0d divn=%0d locked=%0b, expected 0",
                     w_pa, w_ha, w_da, w_la);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_en(0, 1'b0);
    endtask

    task automatic test_div2();
        set_en(0, 1'b1);
        drive_wave(0, 1, 1, 10);
        drain(0);
        n_tests++;
        if ({w_pa, w_ha, w_da, w_la} !== {16'd2, 16'd1, 8'h02, 1'b1}) begin
            n_fail++;
            $display("FAIL div2_final: got period=%0d high=%0d divn=%0d locked=%0b, expected 2 1 2 1",
                     w_pa, w_ha, w_da, w_la);
        end
        set_en(0, 1'b0);
    endtask

    task automatic test_div5_and_300();
        set_en(0, 1'b1);
        drive_wave(0, 3, 2, 6);
        drive_wave(0, 150, 150, 3);
        drain(0);
        n_tests++;
        if ({w_pa, w_ha, w_da} !== {16'd300, 16'd150, 8'hFF}) begin
            n_fail++;
            $display("FAIL div300_final: got period=%0d high=%0d divn=%0d, expected 300 150 255",
                     w_pa, w_ha, w_da);
        end
        set_en(0, 1'b0);
    endtask

    task automatic test_timeout();
        int  k = 0;
        bit  seen = 1'b0;
        set_en(1, 1'b1);
        drive_wave(1, 2, 2, 8);
        while (qb.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (cyc == last_valid_cyc[1] + 254) begin
                n_tests++;
                if ({w_tb, w_lb} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL timeout_early: got timeout=%0b locked=%0b, expected 0 1", w_tb, w_lb);
                end
            end else if (cyc == last_valid_cyc[1] + 255) begin
                seen = 1'b1;
                n_tests++;
                if ({w_tb, w_lb, w_pb, w_db} !== {1'b1, 1'b0, 8'd4, 8'd4}) begin
                    n_fail++;
                    $display("FAIL timeout_flag: got timeout=%0b locked=%0b period=%0d divn=%0d, expected 1 0 4 4",
                             w_tb, w_lb, w_pb, w_db);
                end
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout_wait: got no timeout window, expected one");
        end
        @(posedge clk);
        #1;
        model_clear(1);
        drive_wave(1, 2, 2, 1);
        n_tests++;
        if (w_tb !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_hold: got timeout=%0b, expected 1", w_tb);
        end
        drive_wave(1, 2, 2, 3);
        drain(1);
        n_tests++;
        if ({w_tb, w_pb} !== {1'b0, 8'd4}) begin
            n_fail++;
            $display("FAIL timeout_clear: got timeout=%0b period=%0d, expected 0 4", w_tb, w_pb);
        end
        set_en(1, 1'b0);
    endtask

    task automatic test_lock_switch();
        set_en(1, 1'b1);
        drive_wave(1, 2, 2, 7);
        drive_wave(1, 3, 3, 6);
        drain(1);
        n_tests++;
        if ({w_lb, w_pb, w_hb} !== {1'b1, 8'd6, 8'd3}) begin
            n_fail++;
            $display("FAIL lock_relock: got locked=%0b period=%0d high=%0d, expected 1 6 3", w_lb, w_pb, w_hb);
        end
    endtask

    task automatic test_en_drop_and_coincident();
        repeat (3) tick(1, 1'b1);
        en[1] = 1'b0;
        model_clear(1);
        @(posedge clk);
        #1;
        n_tests++;
        if ({w_vb, w_lb, w_tb, w_pb} !== {3'b000, 8'd6}) begin
            n_fail++;
            $display("FAIL en_drop: got valid=%0b locked=%0b timeout=%0b period=%0d, expected 0 0 0 6",
                     w_vb, w_lb, w_tb, w_pb);
        end
        en[1] = 1'b1;
        repeat (3) tick(1, 1'b0);
        drive_wave(1, 2, 2, 3);
        drain(1);
        drive_wave(1, 100, 155, 3);
        drain(1);
        n_tests++;
        if ({w_pb, w_hb, w_db, w_tb} !== {8'd255, 8'd100, 8'hFF, 1'b0}) begin
            n_fail++;
            $display("FAIL coincident_max: got period=%0d high=%0d divn=%0d timeout=%0b, expected 255 100 255 0",
                     w_pb, w_hb, w_db, w_tb);
        end
        set_en(1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        meas  = 2'b00;
        en    = 2'b00;
        model_clear(0);
        model_clear(1);
        n_valid[0] = 0;
        n_valid[1] = 0;
        last_valid_cyc[0] = 0;
        last_valid_cyc[1] = 0;
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_div2();
        test_div5_and_300();
        test_timeout();
        test_lock_switch();
        test_en_drop_and_coincident();
        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
